// File: rtl/fsk_tone_modulator_if.sv
// Symbol handshake and DAC sample bundle for the CPFSK tone modulator.
interface fsk_tone_modulator_if #(
    parameter int OUT_W = 16
);
    logic [1:0]              mode;
    logic [3:0]              sym_in;
    logic                    sym_valid;
    logic                    sym_ready;
    logic signed [OUT_W-1:0] dac_out_sin;
    logic signed [OUT_W-1:0] dac_out_cos;
    logic                    out_valid;
    logic                    sym_strobe;

    modport master (
        output mode, sym_in, sym_valid,
        input  sym_ready, dac_out_sin, dac_out_cos, out_valid, sym_strobe
    );

    modport slave (
        input  mode, sym_in, sym_valid,
        output sym_ready, dac_out_sin, dac_out_cos, out_valid, sym_strobe
    );
endinterface

// File: rtl/fsk_tone_modulator.sv
// M-ary CPFSK transmitter: per-symbol tone from a phase-accumulator NCO and quarter-wave sine LUT.
// state | meaning
// IDLE  | no symbol in flight, phase_acc holds, ready for a symbol
// RUN   | emitting SYM_LEN samples of the latched tone; ready only on the last sample
module fsk_tone_modulator #(
    parameter int          SYM_LEN  = 100,
    parameter int          PHASE_W  = 32,
    parameter int          LUT_AW   = 8,
    parameter int          OUT_W    = 16,
    parameter int          AMP      = 32000,
    parameter int unsigned FCW_STEP = 32'd42949673
) (
    input logic                 clk,
    input logic                 reset,
    fsk_tone_modulator_if.slave bus
);
    localparam int CNT_W = $clog2(SYM_LEN);
    localparam int MAG_W = OUT_W - 1;
    localparam int TOP_W = LUT_AW + 2;
    localparam int LUT_N = 1 << LUT_AW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);
    localparam logic [TOP_W-1:0] QUARTER  = TOP_W'(1) << LUT_AW;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_next;
    logic                 ready;
    logic                 accept;
    logic                 last_sample;
    logic [3:0]           tone_idx;
    logic [PHASE_W-1:0]   fcw_new;
    logic [PHASE_W-1:0]   fcw;
    logic [PHASE_W-1:0]   phase_acc;
    logic [CNT_W-1:0]     sample_cnt;

    logic                 s1_valid, s1_first;
    logic [TOP_W-1:0]     s1_phase;
    logic [TOP_W-1:0]     cos_phase;
    logic                 s2_valid, s2_first, s2_sin_neg, s2_cos_neg;
    logic [MAG_W-1:0]     s2_sin_mag, s2_cos_mag;
    logic signed [OUT_W-1:0] out_sin, out_cos;
    logic                 out_valid, out_strobe;

    // Midpoint-sampled quarter wave: entries never reach AMP exactly at 0 or pi/2.
    function automatic logic [MAG_W-1:0] lut_val(input int i);
        real x;
        x = real'(AMP) * $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(LUT_N));
        return MAG_W'($rtoi(x + 0.5));
    endfunction

    function automatic logic [LUT_AW-1:0] lut_addr(input logic [TOP_W-2:0] ph);
        return ph[TOP_W-2] ? ~ph[LUT_AW-1:0] : ph[LUT_AW-1:0];
    endfunction

    logic [MAG_W-1:0] lut [LUT_N];
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
        assign lut[gi] = lut_val(gi);
    end

    // Coarser modes spread their symbols evenly over the 16-tone grid.
    always_comb begin
        tone_idx = (bus.sym_in & (4'hF >> bus.mode)) << bus.mode;
        fcw_new  = PHASE_W'((32'(tone_idx) + 32'd1) * FCW_STEP);
    end

    assign last_sample = (sample_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            RUN:     ready = last_sample;
            default: ready = 1'b0;
        endcase
        ready  = ready & ~reset;
        accept = bus.sym_valid & ready;
        if (accept)
            state_next = RUN;
        else if (state == RUN && last_sample)
            state_next = IDLE;
    end

    assign bus.sym_ready = ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_acc  <= '0;
            fcw        <= '0;
            sample_cnt <= '0;
        end else begin
            if (state == RUN)
                phase_acc <= phase_acc + fcw;
            if (accept) begin
                fcw        <= fcw_new;
                sample_cnt <= '0;
            end else if (state == RUN && !last_sample) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

    // Only the quadrant and LUT address bits matter downstream.
    assign cos_phase = s1_phase + QUARTER;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_phase   <= '0;
            s2_valid   <= 1'b0;
            s2_first   <= 1'b0;
            s2_sin_neg <= 1'b0;
            s2_cos_neg <= 1'b0;
            s2_sin_mag <= '0;
            s2_cos_mag <= '0;
            out_sin    <= '0;
            out_cos    <= '0;
            out_valid  <= 1'b0;
            out_strobe <= 1'b0;
        end else begin
            s1_valid   <= (state == RUN);
            s1_first   <= (state == RUN) && (sample_cnt == '0);
            s1_phase   <= phase_acc[PHASE_W-1 -: TOP_W];

            s2_valid   <= s1_valid;
            s2_first   <= s1_first;
            s2_sin_neg <= s1_phase[TOP_W-1];
            s2_cos_neg <= cos_phase[TOP_W-1];
            s2_sin_mag <= lut[lut_addr(s1_phase[TOP_W-2:0])];
            s2_cos_mag <= lut[lut_addr(cos_phase[TOP_W-2:0])];

            out_valid  <= s2_valid;
            out_strobe <= s2_valid & s2_first;
            if (s2_valid) begin
                out_sin <= s2_sin_neg ? -$signed({1'b0, s2_sin_mag}) : $signed({1'b0, s2_sin_mag});
                out_cos <= s2_cos_neg ? -$signed({1'b0, s2_cos_mag}) : $signed({1'b0, s2_cos_mag});
            end else begin
                out_sin <= '0;
                out_cos <= '0;
            end
        end
    end

    assign bus.dac_out_sin = out_sin;
    assign bus.dac_out_cos = out_cos;
    assign bus.out_valid   = out_valid;
    assign bus.sym_strobe  = out_strobe;
endmodule

// File: tb/tb_fsk_tone_modulator.sv
// Self-checking bench for fsk_tone_modulator against an ideal-sinusoid CPFSK model.
`timescale 1ns/1ps
module tb_fsk_tone_modulator;
    localparam int     AMP      = 32000;
    localparam int     SYM_LEN  = 100;
    localparam int     TOL      = 120;
    localparam int     NCYC     = 8192;
    localparam longint FCW_STEP = 42949673;
    localparam real    PI       = 3.14159265358979;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fsk_tone_modulator_if #(.OUT_W(16)) bus ();

    fsk_tone_modulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic cap_valid [NCYC];
    logic cap_strobe[NCYC];
    logic cap_ready [NCYC];
    int   cap_sin   [NCYC];
    int   cap_cos   [NCYC];
    logic exp_valid [NCYC];
    logic exp_strobe[NCYC];
    logic exp_ready [NCYC];
    int   exp_sin   [NCYC];
    int   exp_cos   [NCYC];

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            cap_valid[cyc]  = bus.out_valid;
            cap_strobe[cyc] = bus.sym_strobe;
            cap_ready[cyc]  = bus.sym_ready;
            cap_sin[cyc]    = int'(bus.dac_out_sin);
            cap_cos[cyc]    = int'(bus.dac_out_cos);
        end
    end

    bit [31:0]  model_phase = 32'd0;
    logic [1:0] q_mode[$];
    logic [3:0] q_sym[$];
    int         q_edge[$];

    function automatic bit [31:0] tone_fcw(bit [1:0] md, bit [3:0] s);
        int tones = 16 >> md;
        int k = (int'(s) % tones) * (16 / tones);
        return 32'(longint'(k + 1) * FCW_STEP);
    endfunction

    function automatic int ideal(bit [31:0] ph, bit use_cos);
        real a, v;
        a = 2.0 * PI * real'(ph) / 4294967296.0;
        v = real'(AMP) * (use_cos ? $cos(a) : $sin(a));
        return $rtoi(v < 0.0 ? v - 0.5 : v + 0.5);
    endfunction

    function automatic int absi(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_expect();
        for (int c = 0; c < NCYC; c++) begin
            exp_valid[c]  = 1'b0;
            exp_strobe[c] = 1'b0;
            exp_ready[c]  = 1'b1;
            exp_sin[c]    = 0;
            exp_cos[c]    = 0;
        end
    endtask

    // Ideal CPFSK: each symbol continues from the phase where the previous one stopped.
    task automatic build_expect();
        for (int j = 0; j < q_edge.size(); j++) begin
            bit [31:0] f = tone_fcw(q_mode[j], q_sym[j]);
            for (int n = 0; n < SYM_LEN; n++) begin
                int c = q_edge[j] + 3 + n;
                bit [31:0] ph = model_phase + 32'(n) * f;
                exp_valid[c]  = 1'b1;
                exp_strobe[c] = (n == 0);
                exp_sin[c]    = ideal(ph, 1'b0);
                exp_cos[c]    = ideal(ph, 1'b1);
                if (n < SYM_LEN - 1) exp_ready[q_edge[j] + n] = 1'b0;
            end
            model_phase = model_phase + 32'(SYM_LEN) * f;
        end
    endtask

    task automatic send_queued();
        int idx = 0;
        int waited = 0;
        q_edge.delete();
        bus.mode      = q_mode[0];
        bus.sym_in    = q_sym[0];
        bus.sym_valid = 1'b1;
        while (idx < q_sym.size()) begin
            if (bus.sym_ready === 1'b1) begin
                q_edge.push_back(cyc + 1);
                idx++;
                tick(1);
                waited = 0;
                if (idx < q_sym.size()) begin
                    bus.mode   = q_mode[idx];
                    bus.sym_in = q_sym[idx];
                end else begin
                    bus.sym_valid = 1'b0;
                    bus.mode      = 2'($urandom_range(0, 3));
                    bus.sym_in    = 4'($urandom_range(0, 15));
                end
            end else begin
                tick(1);
                waited++;
                if (waited > 300) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: sym_ready stayed %b, required 1 within 300 cycles", bus.sym_ready);
                    bus.sym_valid = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic drain();
        if (q_edge.size() > 0)
            while (cyc <= q_edge[q_edge.size()-1] + SYM_LEN + 5) tick(1);
        tick(2);
    endtask

    task automatic test_reset();
        bus.sym_valid = 1'b1;
        bus.sym_in    = 4'd5;
        bus.mode      = 2'd0;
        reset         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_checks++;
            if ({bus.out_valid, bus.sym_strobe, bus.sym_ready, bus.dac_out_sin, bus.dac_out_cos} !== 35'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: valid=%b strobe=%b ready=%b sin=%0d cos=%0d, required all 0",
                         bus.out_valid, bus.sym_strobe, bus.sym_ready, bus.dac_out_sin, bus.dac_out_cos);
            end
        end
        reset         = 1'b0;
        bus.sym_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: sym_ready=%b, required 1", bus.sym_ready);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_accept: out_valid=%b, required 0", bus.out_valid);
            end
        end
        model_phase = 32'd0;
    endtask

    task automatic test_single();
        int lo = cyc;
        int pk = 0;
        clear_expect();
        q_mode = '{2'd0};
        q_sym  = '{4'd0};
        send_queued();
        build_expect();
        drain();
        for (int c = lo; c < cyc; c++) begin
            n_checks++;
            if ({cap_valid[c], cap_strobe[c], cap_ready[c]} !== {exp_valid[c], exp_strobe[c], exp_ready[c]}) begin
                n_fail++;
                $display("FAIL single_ctrl cyc=%0d: valid/strobe/ready=%b%b%b, required %b%b%b",
                         c, cap_valid[c], cap_strobe[c], cap_ready[c], exp_valid[c], exp_strobe[c], exp_ready[c]);
            end
            n_checks++;
            if (absi(cap_sin[c] - exp_sin[c]) > (exp_valid[c] ? TOL : 0) ||
                absi(cap_cos[c] - exp_cos[c]) > (exp_valid[c] ? TOL : 0)) begin
                n_fail++;
                $display("FAIL single_sample cyc=%0d: sin=%0d cos=%0d, required %0d %0d",
                         c, cap_sin[c], cap_cos[c], exp_sin[c], exp_cos[c]);
            end
            if (cap_valid[c] === 1'b1 && absi(cap_sin[c]) > pk) pk = absi(cap_sin[c]);
        end
        n_checks++;
        if (pk < 31680 || pk > AMP) begin
            n_fail++;
            $display("FAIL single_peak: peak |sin|=%0d, required 31680..%0d", pk, AMP);
        end
        n_checks++;
        if (absi(cap_cos[q_edge[0] + 13] - cap_sin[q_edge[0] + 38]) > 2) begin
            n_fail++;
            $display("FAIL single_cos_lead: cos[10]=%0d sin[35]=%0d, required equal within 2",
                     cap_cos[q_edge[0] + 13], cap_sin[q_edge[0] + 38]);
        end
    endtask

    task automatic test_back_to_back();
        int lo = cyc;
        clear_expect();
        q_mode = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1};
        q_sym  = '{4'd3, 4'd15, 4'b0001, 4'b1110, 4'd2, 4'd7};
        send_queued();
        build_expect();
        drain();
        for (int j = 1; j < q_edge.size(); j++) begin
            n_checks++;
            if (q_edge[j] - q_edge[j-1] !== SYM_LEN) begin
                n_fail++;
                $display("FAIL b2b_gap sym %0d: accept spacing=%0d, required %0d", j, q_edge[j] - q_edge[j-1], SYM_LEN);
            end
        end
        for (int c = lo; c < cyc; c++) begin
            n_checks++;
            if ({cap_valid[c], cap_strobe[c], cap_ready[c]} !== {exp_valid[c], exp_strobe[c], exp_ready[c]}) begin
                n_fail++;
                $display("FAIL b2b_ctrl cyc=%0d: valid/strobe/ready=%b%b%b, required %b%b%b",
                         c, cap_valid[c], cap_strobe[c], cap_ready[c], exp_valid[c], exp_strobe[c], exp_ready[c]);
            end
            n_checks++;
            if (absi(cap_sin[c] - exp_sin[c]) > (exp_valid[c] ? TOL : 0) ||
                absi(cap_cos[c] - exp_cos[c]) > (exp_valid[c] ? TOL : 0)) begin
                n_fail++;
                $display("FAIL b2b_sample cyc=%0d: sin=%0d cos=%0d, required %0d %0d",
                         c, cap_sin[c], cap_cos[c], exp_sin[c], exp_cos[c]);
            end
        end
    endtask

    task automatic test_underflow();
        int lo = cyc;
        clear_expect();
        q_mode = '{2'd0};
        q_sym  = '{4'd9};
        send_queued();
        build_expect();
        drain();
        tick($urandom_range(3, 20));
        q_mode = '{2'd1};
        q_sym  = '{4'd5};
        send_queued();
        build_expect();
        drain();
        for (int c = lo; c < cyc; c++) begin
            n_checks++;
            if ({cap_valid[c], cap_strobe[c], cap_ready[c]} !== {exp_valid[c], exp_strobe[c], exp_ready[c]}) begin
                n_fail++;
                $display("FAIL underflow_ctrl cyc=%0d: valid/strobe/ready=%b%b%b, required %b%b%b",
                         c, cap_valid[c], cap_strobe[c], cap_ready[c], exp_valid[c], exp_strobe[c], exp_ready[c]);
            end
            n_checks++;
            if (absi(cap_sin[c] - exp_sin[c]) > (exp_valid[c] ? TOL : 0) ||
                absi(cap_cos[c] - exp_cos[c]) > (exp_valid[c] ? TOL : 0)) begin
                n_fail++;
                $display("FAIL underflow_sample cyc=%0d: sin=%0d cos=%0d, required %0d %0d",
                         c, cap_sin[c], cap_cos[c], exp_sin[c], exp_cos[c]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int lo = cyc;
        int e;
        clear_expect();
        q_mode = '{2'd0};
        q_sym  = '{4'd1};
        send_queued();
        build_expect();
        e = q_edge[0];
        tick(53);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int c = e + 54; c < e + 3 + SYM_LEN + 5; c++) begin
            exp_valid[c]  = 1'b0;
            exp_strobe[c] = 1'b0;
            exp_sin[c]    = 0;
            exp_cos[c]    = 0;
            exp_ready[c]  = (c >= e + 55);
        end
        model_phase = 32'd0;
        tick(3);
        q_mode = '{2'd0};
        q_sym  = '{4'd0};
        send_queued();
        build_expect();
        drain();
        for (int c = lo; c < cyc; c++) begin
            n_checks++;
            if ({cap_valid[c], cap_strobe[c], cap_ready[c]} !== {exp_valid[c], exp_strobe[c], exp_ready[c]}) begin
                n_fail++;
                $display("FAIL midreset_ctrl cyc=%0d: valid/strobe/ready=%b%b%b, required %b%b%b",
                         c, cap_valid[c], cap_strobe[c], cap_ready[c], exp_valid[c], exp_strobe[c], exp_ready[c]);
            end
            n_checks++;
            if (absi(cap_sin[c] - exp_sin[c]) > (exp_valid[c] ? TOL : 0) ||
                absi(cap_cos[c] - exp_cos[c]) > (exp_valid[c] ? TOL : 0)) begin
                n_fail++;
                $display("FAIL midreset_sample cyc=%0d: sin=%0d cos=%0d, required %0d %0d",
                         c, cap_sin[c], cap_cos[c], exp_sin[c], exp_cos[c]);
            end
        end
    endtask

    task automatic test_random();
        int lo = cyc;
        clear_expect();
        for (int b = 0; b < 8; b++) begin
            int len = $urandom_range(1, 3);
            q_mode.delete();
            q_sym.delete();
            for (int j = 0; j < len; j++) begin
                q_mode.push_back(2'($urandom_range(0, 3)));
                q_sym.push_back(4'($urandom_range(0, 15)));
            end
            send_queued();
            build_expect();
            if ($urandom_range(0, 1) == 1) begin
                drain();
                tick($urandom_range(0, 10));
            end
        end
        drain();
        for (int c = lo; c < cyc; c++) begin
            n_checks++;
            if ({cap_valid[c], cap_strobe[c], cap_ready[c]} !== {exp_valid[c], exp_strobe[c], exp_ready[c]}) begin
                n_fail++;
                $display("FAIL random_ctrl cyc=%0d: valid/strobe/ready=%b%b%b, required %b%b%b",
                         c, cap_valid[c], cap_strobe[c], cap_ready[c], exp_valid[c], exp_strobe[c], exp_ready[c]);
            end
            n_checks++;
            if (absi(cap_sin[c] - exp_sin[c]) > (exp_valid[c] ? TOL : 0) ||
                absi(cap_cos[c] - exp_cos[c]) > (exp_valid[c] ? TOL : 0)) begin
                n_fail++;
                $display("FAIL random_sample cyc=%0d: sin=%0d cos=%0d, required %0d %0d",
                         c, cap_sin[c], cap_cos[c], exp_sin[c], exp_cos[c]);
            end
        end
    endtask

    initial begin
        bus.mode      = 2'd0;
        bus.sym_in    = 4'd0;
        bus.sym_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_underflow();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
